// File: rtl/arf_sched.sv
// ---------------------------------------------------------------------------
// arf_sched -- in-order scoreboard scheduler for a small arithmetic register
// file with one shared pipelined multiplier and one shared pipelined adder.
//
// A program of up to PROG_DEPTH ops lives in an op table loaded through the
// cfg_* port while idle. On start, the ops are issued one per cycle, strictly
// in table order. An op waits while any of its sources or its destination has
// an outstanding write (RAW/WAW interlock, no bypass). Each unit returns its
// result MUL_LAT / ADD_LAT cycles after issue on its own write-back port.
//
// Parameters
//   PROG_DEPTH : op-table entries (2..32)
//   MUL_LAT    : multiplier latency in cycles (1..4)
//   ADD_LAT    : adder latency in cycles (1..4)
//
// Ports
//   clk, rst                   : clock (rising edge), async active-high reset
//   cfg_we/cfg_addr/cfg_data   : op-table write, honoured only while idle
//                                entry = {type(1=add), src_a, src_b, dst}
//   prog_len, start            : program length (0..32) and run request
//   iss_mul/iss_add            : issue strobes to the shared units
//   iss_src_a/iss_src_b        : register-file read addresses of the issue
//   wb_mul_en/wb_mul_addr      : multiplier write-back strobe and destination
//   wb_add_en/wb_add_addr      : adder write-back strobe and destination
//   busy, done, stall_cnt      : run status, end-of-run pulse, stall cycles
// ---------------------------------------------------------------------------
module arf_sched #(
   parameter int PROG_DEPTH = 32,
   parameter int MUL_LAT    = 2,
   parameter int ADD_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [4:0]  cfg_addr,
   input  logic [15:0] cfg_data,
   input  logic [5:0]  prog_len,
   input  logic        start,
   output logic        iss_mul,
   output logic        iss_add,
   output logic [4:0]  iss_src_a,
   output logic [4:0]  iss_src_b,
   output logic        wb_mul_en,
   output logic        wb_add_en,
   output logic [4:0]  wb_mul_addr,
   output logic [4:0]  wb_add_addr,
   output logic        busy,
   output logic        done,
   output logic [15:0] stall_cnt
);

   localparam int         AW      = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
   localparam logic [6:0] DEPTH_V = 7'(PROG_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   state_t       r_state;
   state_t       w_state_nxt;

   logic [15:0]  r_table [PROG_DEPTH];
   logic [5:0]   r_pc;
   logic [5:0]   r_len;
   logic [31:0]  r_pending;
   logic [15:0]  r_stall_cnt;

   logic [MUL_LAT-1:0] r_mul_vld;
   logic [4:0]         r_mul_dst [MUL_LAT];
   logic [ADD_LAT-1:0] r_add_vld;
   logic [4:0]         r_add_dst [ADD_LAT];

   logic [15:0]  w_op;
   logic [4:0]   w_src_a;
   logic [4:0]   w_src_b;
   logic [4:0]   w_dst;
   logic         w_hazard;
   logic         w_can_issue;
   logic         w_last;
   logic         w_start_acc;
   logic [5:0]   w_len_eff;
   logic [31:0]  w_clr;
   logic [31:0]  w_set;
   logic [31:0]  w_pending_nxt;
   logic         w_inflight_mid;

   // Op-table storage: deliberately has no reset so a program survives rst.
   always_ff @(posedge clk) begin
      if (cfg_we && (r_state == ST_IDLE) && ({2'b00, cfg_addr} < DEPTH_V)) begin
         r_table[cfg_addr[AW-1:0]] <= cfg_data;
      end
   end

   // Decode of the op at pc and the interlock / issue decision.
   always_comb begin
      w_op        = r_table[r_pc[AW-1:0]];
      w_src_a     = w_op[14:10];
      w_src_b     = w_op[9:5];
      w_dst       = w_op[4:0];
      w_hazard    = r_pending[w_src_a] | r_pending[w_src_b] | r_pending[w_dst];
      w_can_issue = (r_state == ST_RUN) && !w_hazard;
      w_last      = ((r_pc + 6'd1) == r_len);
      w_start_acc = (r_state == ST_IDLE) && start;
      // Lengths beyond the table size are clamped so pc never leaves the table.
      w_len_eff   = ({1'b0, prog_len} > DEPTH_V) ? DEPTH_V[5:0] : prog_len;
   end

   // Pending-bit update: write-backs clear at the end of their cycle, issue sets.
   always_comb begin
      w_clr         = (32'(wb_mul_en) << wb_mul_addr) | (32'(wb_add_en) << wb_add_addr);
      w_set         = 32'(w_can_issue) << w_dst;
      w_pending_nxt = (r_pending & ~w_clr) | w_set;
   end

   // Any in-flight slot other than the one writing back this cycle.
   always_comb begin
      w_inflight_mid = 1'b0;
      for (int i = 0; i < MUL_LAT - 1; i++) begin
         w_inflight_mid = w_inflight_mid | r_mul_vld[i];
      end
      for (int i = 0; i < ADD_LAT - 1; i++) begin
         w_inflight_mid = w_inflight_mid | r_add_vld[i];
      end
   end

   // Next-state logic. DRAIN looks at the post-write-back pending set so FIN
   // follows the final write-back cycle directly.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = (w_len_eff == 6'd0) ? ST_DRAIN : ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_can_issue && w_last) begin
               w_state_nxt = ST_DRAIN;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if ((w_pending_nxt == 32'd0) && !w_inflight_mid) begin
               w_state_nxt = ST_FIN;
            end else begin
               w_state_nxt = ST_DRAIN;
            end
         end
         ST_FIN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, program counter, scoreboard and stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_pc        <= 6'd0;
         r_len       <= 6'd0;
         r_pending   <= 32'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         if (w_start_acc) begin
            r_len       <= w_len_eff;
            r_pc        <= 6'd0;
            r_stall_cnt <= 16'd0;
         end else if (w_can_issue) begin
            r_pc <= r_pc + 6'd1;
         end else if ((r_state == ST_RUN) && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   // Unit pipelines: a token enters stage 0 on issue and writes back from the
   // last stage, giving exactly LAT cycles from issue to write-back.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mul_vld <= '0;
         r_add_vld <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            r_mul_dst[i] <= 5'd0;
         end
         for (int i = 0; i < ADD_LAT; i++) begin
            r_add_dst[i] <= 5'd0;
         end
      end else begin
         r_mul_vld[0] <= iss_mul;
         r_mul_dst[0] <= iss_mul ? w_dst : 5'd0;
         r_add_vld[0] <= iss_add;
         r_add_dst[0] <= iss_add ? w_dst : 5'd0;
         for (int i = MUL_LAT - 1; i > 0; i--) begin
            r_mul_vld[i] <= r_mul_vld[i-1];
            r_mul_dst[i] <= r_mul_dst[i-1];
         end
         for (int i = ADD_LAT - 1; i > 0; i--) begin
            r_add_vld[i] <= r_add_vld[i-1];
            r_add_dst[i] <= r_add_dst[i-1];
         end
      end
   end

   // Output drive. Issue fields read 0 unless an op actually issues.
   always_comb begin
      iss_mul     = w_can_issue && !w_op[15];
      iss_add     = w_can_issue &&  w_op[15];
      iss_src_a   = w_can_issue ? w_src_a : 5'd0;
      iss_src_b   = w_can_issue ? w_src_b : 5'd0;
      wb_mul_en   = r_mul_vld[MUL_LAT-1];
      wb_mul_addr = r_mul_dst[MUL_LAT-1];
      wb_add_en   = r_add_vld[ADD_LAT-1];
      wb_add_addr = r_add_dst[ADD_LAT-1];
      busy        = (r_state == ST_RUN) || (r_state == ST_DRAIN);
      done        = (r_state == ST_FIN);
      stall_cnt   = r_stall_cnt;
   end

endmodule

// File: tb/tb_arf_sched.sv
// ---------------------------------------------------------------------------
// tb_arf_sched -- self-checking bench for arf_sched (default parameters).
// Expected per-cycle events (issue, write-back, done) are queued when a run is
// started and popped as the DUT produces them. Cycle 0 is the cycle in which
// start is driven; cycle n is n rising edges later.
// Event kinds: 0 iss_mul, 1 iss_add, 2 wb_mul, 3 wb_add, 4 done.
// ---------------------------------------------------------------------------
module tb_arf_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [15:0] cfg_data;
   logic [5:0]  prog_len;
   logic        start;
   logic        iss_mul, iss_add;
   logic [4:0]  iss_src_a, iss_src_b;
   logic        wb_mul_en, wb_add_en;
   logic [4:0]  wb_mul_addr, wb_add_addr;
   logic        busy, done;
   logic [15:0] stall_cnt;
   logic [41:0] outs;

   assign outs = {iss_mul, iss_add, iss_src_a, iss_src_b, wb_mul_en, wb_add_en,
                  wb_mul_addr, wb_add_addr, busy, done, stall_cnt};

   arf_sched dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .prog_len(prog_len), .start(start),
      .iss_mul(iss_mul), .iss_add(iss_add), .iss_src_a(iss_src_a),
      .iss_src_b(iss_src_b), .wb_mul_en(wb_mul_en), .wb_add_en(wb_add_en),
      .wb_mul_addr(wb_mul_addr), .wb_add_addr(wb_add_addr), .busy(busy),
      .done(done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; int kind; int a; int b; } exp_t;
   typedef struct { int sid; int cyc; int kind; int a; int b; } ev_t;
   typedef struct { logic [15:0] op0; logic [15:0] op1; logic [5:0] len; int stall; } vec_t;

   exp_t sb_q[$];
   ev_t  evs[$];
   vec_t vecs[5];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check_val(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_ev(input int cyc, input int kind, input int a, input int b);
      exp_t e;
      n_tests++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_event: got cyc=%0d kind=%0d a=%0d b=%0d, expected no event",
                  cyc, kind, a, b);
      end else begin
         e = sb_q.pop_front();
         if (e.cyc != cyc || e.kind != kind || e.a != a || e.b != b) begin
            n_fail++;
            $display("FAIL event: got cyc=%0d kind=%0d a=%0d b=%0d, expected cyc=%0d kind=%0d a=%0d b=%0d",
                     cyc, kind, a, b, e.cyc, e.kind, e.a, e.b);
         end
      end
   endtask

   task automatic sample_events(input int cyc);
      if (iss_mul)   check_ev(cyc, 0, int'(iss_src_a), int'(iss_src_b));
      if (iss_add)   check_ev(cyc, 1, int'(iss_src_a), int'(iss_src_b));
      if (wb_mul_en) check_ev(cyc, 2, int'(wb_mul_addr), 0);
      if (wb_add_en) check_ev(cyc, 3, int'(wb_add_addr), 0);
      if (done)      check_ev(cyc, 4, 0, 0);
   endtask

   task automatic add_ev(input int sid, input int c, input int k, input int a, input int b);
      ev_t e;
      e = '{sid, c, k, a, b};
      evs.push_back(e);
   endtask

   task automatic push_exp(input int c, input int k, input int a, input int b);
      exp_t e;
      e = '{c, k, a, b};
      sb_q.push_back(e);
   endtask

   task automatic push_sid(input int sid);
      foreach (evs[i]) begin
         if (evs[i].sid == sid) push_exp(evs[i].cyc, evs[i].kind, evs[i].a, evs[i].b);
      end
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(posedge clk); #1;
      cfg_we   = 1'b0;
   endtask

   // Starts a run and compares every strobe against the queue. inj_cyc pokes
   // cfg_we and start while busy; abort_cyc asserts rst inside that cycle.
   task automatic run_check(input string name, input int budget, input int exp_stall,
                            input bit exp_done, input int inj_cyc, input int abort_cyc);
      int cyc;
      bit seen_done;
      cyc       = 0;
      seen_done = 1'b0;
      start     = 1'b1;
      while (!seen_done && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         start  = 1'b0;
         cfg_we = 1'b0;
         rst    = 1'b0;
         if (cyc == inj_cyc) begin
            cfg_we   = 1'b1;
            cfg_addr = 5'd0;
            cfg_data = 16'h90A6;
            start    = 1'b1;
         end
         if (cyc == abort_cyc) rst = 1'b1;
         @(negedge clk);
         if (cyc == 1 && abort_cyc != 1) check_val({name, "_busy_c1"}, longint'(busy), 1);
         if (cyc == abort_cyc) check_val({name, "_outs_in_rst"}, longint'(outs), 0);
         sample_events(cyc);
         if (done) seen_done = 1'b1;
      end
      if (exp_done) check_val({name, "_done_seen"}, longint'(seen_done), 1);
      check_val({name, "_stall_cnt"}, longint'(stall_cnt), longint'(exp_stall));
      check_val({name, "_busy_end"}, longint'(busy), 0);
      check_val({name, "_leftover_exp"}, longint'(sb_q.size()), 0);
      sb_q.delete();
      @(posedge clk); #1;
      start  = 1'b0;
      cfg_we = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
      check_val({name, "_done_after"}, longint'(done), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      // Scenario table: two-op programs with expected stall count.
      vecs[0] = '{16'h0443, 16'h1085, 6'd2, 0};   // independent muls
      vecs[1] = '{16'h0443, 16'h8C26, 6'd2, 2};   // mul r3 then add r3+r1 -> RAW
      vecs[2] = '{16'h8447, 16'h90A7, 6'd2, 1};   // two adds into r7 -> WAW
      vecs[3] = '{16'h0443, 16'h1085, 6'd0, 0};   // empty program
      vecs[4] = '{16'h0443, 16'h90A6, 6'd2, 0};   // mul + add, same-cycle write-backs
      add_ev(0, 1, 0, 1, 2); add_ev(0, 2, 0, 4, 4); add_ev(0, 3, 2, 3, 0);
      add_ev(0, 4, 2, 5, 0); add_ev(0, 5, 4, 0, 0);
      add_ev(1, 1, 0, 1, 2); add_ev(1, 3, 2, 3, 0); add_ev(1, 4, 1, 3, 1);
      add_ev(1, 5, 3, 6, 0); add_ev(1, 6, 4, 0, 0);
      add_ev(2, 1, 1, 1, 2); add_ev(2, 2, 3, 7, 0); add_ev(2, 3, 1, 4, 5);
      add_ev(2, 4, 3, 7, 0); add_ev(2, 5, 4, 0, 0);
      add_ev(3, 2, 4, 0, 0);
      add_ev(4, 1, 0, 1, 2); add_ev(4, 2, 1, 4, 5); add_ev(4, 3, 2, 3, 0);
      add_ev(4, 3, 3, 6, 0); add_ev(4, 4, 4, 0, 0);

      rst      = 1'b1;
      cfg_we   = 1'b0;
      cfg_addr = 5'd0;
      cfg_data = 16'd0;
      prog_len = 6'd0;
      start    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("reset_outputs", longint'(outs), 0);
      check_val("reset_busy", longint'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int s = 0; s < 5; s++) begin
         cfg_write(5'd0, vecs[s].op0);
         cfg_write(5'd1, vecs[s].op1);
         prog_len = vecs[s].len;
         push_sid(s);
         run_check($sformatf("vec%0d", s), 20, vecs[s].stall, 1'b1, -1, -1);
      end

      // Reset in cycle 2 of the independent-mul run, then a clean rerun.
      cfg_write(5'd0, 16'h0443);
      cfg_write(5'd1, 16'h1085);
      prog_len = 6'd2;
      push_exp(1, 0, 1, 2);
      run_check("abort", 10, 0, 1'b0, -1, 2);
      push_sid(0);
      run_check("rerun_after_rst", 20, 0, 1'b1, -1, -1);

      // cfg_we and start while busy must not disturb the run or the table.
      cfg_write(5'd0, 16'h0443);
      cfg_write(5'd1, 16'h8C26);
      prog_len = 6'd2;
      push_sid(1);
      run_check("cfg_while_busy", 20, 2, 1'b1, 2, -1);
      push_sid(1);
      run_check("cfg_rerun", 20, 2, 1'b1, -1, -1);

      // Full-depth program: 32 back-to-back adds, rd = rs = i, no wrap.
      for (int i = 0; i < 32; i++) begin
         cfg_write(5'(i), 16'h8000 | 16'(i << 10) | 16'(i << 5) | 16'(i));
      end
      prog_len = 6'd32;
      push_exp(1, 1, 0, 0);
      for (int c = 2; c <= 32; c++) begin
         push_exp(c, 1, c - 1, c - 1);
         push_exp(c, 3, c - 2, 0);
      end
      push_exp(33, 3, 31, 0);
      push_exp(34, 4, 0, 0);
      run_check("len32", 45, 0, 1'b1, -1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arf_sched.md
ARF_SCHED -- requirements
Module: arf_sched

Interface
REQ-001 SHALL have parameter PROG_DEPTH, default 32, maximum op-table entries.
REQ-002 SHALL have parameter MUL_LAT, default 2, shared-multiplier latency in cycles (1..4).
REQ-003 SHALL have parameter ADD_LAT, default 1, shared-adder latency in cycles (1..4).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_we  in  1  op-table write strobe.
REQ-007 SHALL have port cfg_addr  in  5  op-table write address.
REQ-008 SHALL have port cfg_data  in  16  op entry: [15] type (0 mul, 1 add), [14:10] src_a, [9:5] src_b, [4:0] dst.
REQ-009 SHALL have port prog_len  in  6  number of ops to run (0..32), sampled on start.
REQ-010 SHALL have port start  in  1  run request.
REQ-011 SHALL have ports iss_mul / iss_add  out  1 each  issue strobe to the shared multiplier / adder.
REQ-012 SHALL have ports iss_src_a / iss_src_b  out  5 each  register-file read addresses for the issued op.
REQ-013 SHALL have ports wb_mul_en / wb_add_en  out  1 each, and wb_mul_addr / wb_add_addr  out  5 each  write-back strobes and destinations.
REQ-014 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), stall_cnt  out  16  stall cycles in the last run.

Function
REQ-015 SHALL implement FSM IDLE, RUN, DRAIN, FIN; FIN lasts exactly one cycle with done=1, then returns to IDLE.
REQ-016 IDLE: start=1 SHALL latch prog_len, clear pc and stall_cnt, and go to RUN (or DRAIN if prog_len=0).
REQ-017 SHALL write cfg_data to table[cfg_addr] on cfg_we only in IDLE; cfg_we in any other state SHALL be ignored.
REQ-018 start while busy SHALL be ignored; busy SHALL be 1 in RUN and DRAIN only.
REQ-019 RUN: at most one op SHALL issue per cycle, strictly in table order from pc=0.
REQ-020 Op at pc SHALL issue only if src_a, src_b and dst all have clear pending bits (RAW and WAW interlock); otherwise it stalls and stall_cnt increments (saturating at 0xFFFF).
REQ-021 On issue: pending[dst] SHALL be set; the matching iss_* strobe SHALL be 1 for that cycle, with iss_src_a/b driven; pc increments.
REQ-022 Op issued in cycle t SHALL assert wb_*_en with wb_*_addr=dst in cycle t+MUL_LAT (mul) or t+ADD_LAT (add) and clear pending[dst] at the end of that cycle; a dependent op SHALL issue no earlier than the following cycle (no bypass).
REQ-023 Multiplier and adder write-backs in the same cycle SHALL both be asserted (two write ports); no arbitration required.
REQ-024 Both units are fully pipelined: back-to-back independent issues to the same unit SHALL be allowed.
REQ-025 After the last op issues, FSM SHALL go to DRAIN and remain until all pending bits and in-flight pipeline slots are clear, then go to FIN.
REQ-026 Outside RUN, iss_mul, iss_add SHALL be 0; iss_src_a/b SHALL hold 0.
REQ-027 pc SHALL not wrap: prog_len=32 runs entries 0..31 exactly once.
REQ-028 Table contents SHALL be retained across runs and across rst (storage not reset).

Reset
REQ-029 rst=1 SHALL immediately force FSM to IDLE, clear pc, pending bits, in-flight pipeline slots, and set all outputs to 0 (stall_cnt=0).
REQ-030 rst asserted mid-run SHALL abort: no further iss_* or wb_* strobes, no done pulse.

Verification
REQ-031 Two independent muls (table[0]=0x0443 r1*r2->r3, table[1]=0x1085 r4*r4->r5), prog_len=2, start in cycle 0 -> iss_mul in cycles 1,2; wb_mul_en cycles 3,4 (addrs 3,5); done cycle 5; stall_cnt=0.
REQ-032 Mul r1*r2->r3 then add r3+r1->r6, start cycle 0 -> mul issue 1, wb 3, add issue 4, wb 5, done 6, stall_cnt=2.
REQ-033 WAW: two adds both dst=r7, independent sources -> second issue stalls until cycle after first wb; stall_cnt=1 with ADD_LAT=1.
REQ-034 prog_len=0, start -> busy for one cycle (DRAIN), done next cycle, no iss_*/wb_* strobes.
REQ-035 rst pulsed during cycle 2 of scenario REQ-031 -> all outputs 0 next cycle, no wb or done afterwards; a new start reruns correctly from pc=0 with the same table.
REQ-036 cfg_we while busy -> table unchanged, verified by rerunning and comparing issue trace.
